// File: rtl/stroke_ratio_ctrl.sv
// stroke_ratio_ctrl: tracks erg drive/recovery phases, measures each phase length in cycles and
// hands completed strokes to a shared divider, publishing the recovery/drive quotient as ratio.
module stroke_ratio_ctrl #(
   parameter int unsigned      CNT_W     = 32,
   parameter int unsigned      MIN_PHASE = 16,
   parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(24'hFFFFFF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_drive,
   input  logic             start_recovery,
   output logic             div_start,
   output logic [CNT_W-1:0] div_num,
   output logic [CNT_W-1:0] div_den,
   input  logic             div_done,
   input  logic [31:0]      div_result,
   output logic [31:0]      ratio,
   output logic             ratio_valid,
   output logic [15:0]      stroke_count,
   output logic [1:0]       phase,
   output logic             timeout_err,
   output logic             overrun_err
);
   typedef enum logic [1:0] {P_IDLE = 2'd0, P_DRIVE = 2'd1, P_RECOVERY = 2'd2} phase_e;
   typedef enum logic {D_IDLE = 1'b0, D_WAIT = 1'b1} div_state_e;

   localparam logic [CNT_W-1:0] MIN_LEN  = CNT_W'(MIN_PHASE);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] LEN_MAX  = {CNT_W{1'b1}};

   logic             drv_q, drv_d, rec_q, rec_d;
   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] len_q, len_d, drive_len_q, drive_len_d;
   div_state_e       dstate_q, dstate_d;
   logic             div_start_q, div_start_d;
   logic [CNT_W-1:0] div_num_q, div_num_d, div_den_q, div_den_d;
   logic [31:0]      ratio_q, ratio_d;
   logic             ratio_valid_q, ratio_valid_d;
   logic [15:0]      stroke_count_q, stroke_count_d;
   logic             timeout_err_q, timeout_err_d;
   logic             overrun_err_q, overrun_err_d;

   logic             rise_drv_s, rise_rec_s, stroke_done_s, accept_s;
   logic [CNT_W-1:0] len_sat_s;

   // Next-state for the phase tracker and the divide handshake.
   always_comb begin
      rise_drv_s     = start_drive & ~drv_q;
      rise_rec_s     = start_recovery & ~rec_q;
      len_sat_s      = (len_q == LEN_MAX) ? len_q : len_q + ONE;
      drv_d          = start_drive;
      rec_d          = start_recovery;
      stroke_done_s  = 1'b0;
      phase_d        = phase_q;
      len_d          = len_sat_s;
      drive_len_d    = drive_len_q;
      timeout_err_d  = 1'b0;

      // len_q counts cycles since the last accepted edge; a new phase restarts at 1 so the
      // accepting edge itself is the first counted cycle (edge-to-edge, no gap).
      case (phase_q)
         P_IDLE: begin
            if (rise_drv_s) begin
               phase_d = P_DRIVE;
               len_d   = ONE;
            end else begin
               phase_d = P_IDLE;
               len_d   = ZERO;
            end
         end
         P_DRIVE: begin
            if (len_q >= TIMEOUT) begin
               phase_d       = P_IDLE;
               len_d         = ZERO;
               timeout_err_d = 1'b1;
            end else if (rise_rec_s && (len_q >= MIN_LEN)) begin
               phase_d     = P_RECOVERY;
               drive_len_d = len_q;
               len_d       = ONE;
            end else begin
               phase_d = P_DRIVE;
            end
         end
         P_RECOVERY: begin
            if (len_q >= TIMEOUT) begin
               phase_d       = P_IDLE;
               len_d         = ZERO;
               timeout_err_d = 1'b1;
            end else if (rise_drv_s && (len_q >= MIN_LEN)) begin
               phase_d       = P_DRIVE;
               len_d         = ONE;
               stroke_done_s = 1'b1;
            end else begin
               phase_d = P_RECOVERY;
            end
         end
         default: begin
            phase_d = P_IDLE;
            len_d   = ZERO;
         end
      endcase

      accept_s       = (dstate_q == D_WAIT) && div_done;
      dstate_d       = dstate_q;
      div_start_d    = 1'b0;
      div_num_d      = div_num_q;
      div_den_d      = div_den_q;
      ratio_d        = ratio_q;
      ratio_valid_d  = 1'b0;
      stroke_count_d = stroke_count_q;
      overrun_err_d  = 1'b0;

      if (accept_s) begin
         ratio_d        = div_result;
         ratio_valid_d  = 1'b1;
         stroke_count_d = stroke_count_q + 16'd1;
         dstate_d       = D_IDLE;
      end else begin
         dstate_d = dstate_q;
      end

      // A result retiring this cycle frees the divider for the stroke completing now.
      if (stroke_done_s && (drive_len_q != ZERO)) begin
         if ((dstate_q == D_IDLE) || accept_s) begin
            div_start_d = 1'b1;
            div_num_d   = len_q;
            div_den_d   = drive_len_q;
            dstate_d    = D_WAIT;
         end else begin
            overrun_err_d = 1'b1;
         end
      end else begin
         div_start_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drv_q          <= 1'b0;
         rec_q          <= 1'b0;
         phase_q        <= P_IDLE;
         len_q          <= ZERO;
         drive_len_q    <= ZERO;
         dstate_q       <= D_IDLE;
         div_start_q    <= 1'b0;
         div_num_q      <= ZERO;
         div_den_q      <= ZERO;
         ratio_q        <= 32'd0;
         ratio_valid_q  <= 1'b0;
         stroke_count_q <= 16'd0;
         timeout_err_q  <= 1'b0;
         overrun_err_q  <= 1'b0;
      end else begin
         drv_q          <= drv_d;
         rec_q          <= rec_d;
         phase_q        <= phase_d;
         len_q          <= len_d;
         drive_len_q    <= drive_len_d;
         dstate_q       <= dstate_d;
         div_start_q    <= div_start_d;
         div_num_q      <= div_num_d;
         div_den_q      <= div_den_d;
         ratio_q        <= ratio_d;
         ratio_valid_q  <= ratio_valid_d;
         stroke_count_q <= stroke_count_d;
         timeout_err_q  <= timeout_err_d;
         overrun_err_q  <= overrun_err_d;
      end
   end

   assign div_start    = div_start_q;
   assign div_num      = div_num_q;
   assign div_den      = div_den_q;
   assign ratio        = ratio_q;
   assign ratio_valid  = ratio_valid_q;
   assign stroke_count = stroke_count_q;
   assign phase        = phase_q;
   assign timeout_err  = timeout_err_q;
   assign overrun_err  = overrun_err_q;

endmodule
